data_mem_interface: RTL and testbench
=====================================

Name: data_mem_interface

Overview:
- Memory-access stage directly downstream of the control logic unit.
- Consumes read_mem, write_mem, store_byte and load_byte, the ALU address and the rs2 store data.
- Runs a single-outstanding request/acknowledge transaction on the data bus.
- Stalls the pipeline until the transaction completes, then presents formatted load data to writeback (mem_to_reg path).

Parameters:
- ADDR_W, 32, bus address width.
- DATA_W, 32, data width. Fixed at 32; byte lanes assume 4 bytes.
- TIMEOUT, 16, maximum cycles spent in BUS waiting for bus_ack before aborting. Must be ≥2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- read_mem  in  1  load request from control logic.
- write_mem  in  1  store request from control logic.
- load_byte  in  1  load is lb (else lw).
- store_byte  in  1  store is sb (else sw).
- address  in  ADDR_W  effective address from ALU.
- store_data  in  DATA_W  rs2 value.
- bus_rdata  in  DATA_W  read data, valid when bus_ack=1.
- bus_ack  in  1  slave acknowledge.
- bus_addr  out  ADDR_W  registered, word-aligned (bits [1:0]=0).
- bus_wdata  out  DATA_W  registered write data.
- bus_sel  out  4  registered byte enables.
- bus_read  out  1  registered read strobe.
- bus_write  out  1  registered write strobe.
- load_data  out  DATA_W  registered formatted load result.
- data_valid  out  1  one-cycle pulse: load_data is valid.
- bus_error  out  1  one-cycle pulse: transaction aborted by timeout.
- stall  out  1  combinational; freezes PC and upstream registers.

Behaviour:
- Reset (async, rst=1): state=IDLE.
  - All registered outputs cleared: bus_addr, bus_wdata, bus_sel, bus_read, bus_write, load_data, data_valid, bus_error = 0.
  - Timeout counter = 0.
  - Asserting reset mid-transaction drops bus strobes immediately. No completion or error pulse is produced.
- States: IDLE, BUS, DONE.
- IDLE:
  - stall = read_mem | write_mem.
  - On a request, the following are latched and the FSM enters BUS with counter=0:
    - bus_addr = {address[ADDR_W-1:2], 2'b00}
    - bus_sel / bus_wdata, per the lane rules below
    - load type and address[1:0], retained for formatting
    - bus_write = write_mem; bus_read = read_mem & ~write_mem
  - If write_mem and read_mem are both high, the write wins and the read is dropped.
  - bus_ack is ignored in IDLE.
- Store lane rules:
  - sw: sel = 4'b1111, wdata = store_data.
  - sb: sel = 4'b0001 << address[1:0], wdata = store_data[7:0] replicated to all 4 bytes.
- Read lane rules: sel = 4'b1111 for both lb and lw.
- BUS:
  - stall=1. Strobes, address, sel and wdata are held stable until bus_ack.
  - Counter increments each cycle.
  - On bus_ack=1:
    - Strobes are cleared at the next edge and the FSM goes to DONE.
    - For a read, load_data is registered:
      - lw: load_data = bus_rdata. Misaligned lw ignores address[1:0].
      - lb: select byte address[1:0] of bus_rdata and sign-extend it to 32 bits.
    - data_valid is set for reads only.
  - If the counter reaches TIMEOUT-1 with no ack:
    - Strobes are cleared, load_data = 0, bus_error = 1, data_valid = 0.
    - The FSM goes to DONE.
  - If ack and timeout occur in the same cycle, the ack wins.
- DONE:
  - stall=0, so the pipeline advances at the end of this cycle.
  - data_valid and bus_error pulse for exactly this cycle. load_data holds until the next read completes.
  - Request inputs are ignored in DONE, because they still reflect the finishing instruction.
  - Next state is always IDLE.
- Latency:
  - Request seen in cycle 0; bus strobes visible in cycle 1.
  - Zero-wait ack in cycle 1 gives DONE in cycle 2.
  - stall is high in cycles 0–1, so the minimum penalty is 2 stall cycles.
  - The timeout path gives TIMEOUT+1 stall cycles.
- Non-memory instructions: stall=0 and no bus activity.

Decomposition:
- Shared package (alongside fop_t and b_t):
  - mem_state_t enum {IDLE, BUS, DONE}
  - constant SEL_WORD = 4'b1111
  - constant SEL_BYTE0 = 4'b0001
- Sub-module byte_lane_formatter (combinational):
  - Computes sel/wdata from (store_byte, addr[1:0], store_data).
  - Computes formatted load data from (load_byte, addr[1:0], bus_rdata).
  - Instantiated once; verified standalone.

Test Plan:
- lw at address 0x0000_0104; bus_ack 2 cycles after bus_read rises, rdata 0xDEADBEEF.
  - Expect bus_addr=0x104, sel=4'b1111, stall high for 3 cycles.
  - Expect data_valid pulse with load_data=0xDEADBEEF.
- sb at 0x0000_0103, store_data 0x1234_56AB; ack in first BUS cycle.
  - Expect bus_addr=0x100, sel=4'b1000, wdata=0xABABABAB, bus_write for 1 cycle, no data_valid.
- lb at 0x0000_0102, rdata 0x12F4_5678 → load_data=0xFFFF_FFF4.
  - Repeat at 0x101 → load_data=0x0000_0056.
- TIMEOUT=16, lw with bus_ack never asserted.
  - Strobe held 16 cycles, then bus_error pulse with load_data=0 and data_valid=0.
  - stall falls in DONE; FSM returns to IDLE.
- rst asserted mid-BUS on a sw, between clock edges.
  - bus_write/bus_sel go to 0 immediately and state=IDLE.
  - A late bus_ack after reset release causes no pulse.
- read_mem=1 and write_mem=1 together at 0x200.
  - Only bus_write asserts; bus_read stays 0 for the whole transaction.
  - An ack in IDLE with no request produces no outputs.

Source files
------------

// File: rtl/data_mem_interface_pkg.sv
// rtl/data_mem_interface_pkg.sv - shared types and constants for the memory-access stage
package data_mem_interface_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    localparam logic [3:0] SEL_WORD  = 4'b1111;
    localparam logic [3:0] SEL_BYTE0 = 4'b0001;

endpackage

// File: rtl/data_mem_interface_byte_lane_formatter.sv
// rtl/data_mem_interface_byte_lane_formatter.sv - store lane steering and load byte extraction
module byte_lane_formatter
    import data_mem_interface_pkg::*;
(
    input  logic        store_byte,
    input  logic [1:0]  st_off,
    input  logic [31:0] store_data,
    output logic [3:0]  sel,
    output logic [31:0] wdata,
    input  logic        load_byte,
    input  logic [1:0]  ld_off,
    input  logic [31:0] rdata,
    output logic [31:0] load_data
);

    logic [7:0] ld_byte;

    always_comb begin
        sel       = store_byte ? (SEL_BYTE0 << st_off) : SEL_WORD;
        wdata     = store_byte ? {4{store_data[7:0]}} : store_data;
        ld_byte   = rdata[{ld_off, 3'b000} +: 8];
        load_data = load_byte ? {{24{ld_byte[7]}}, ld_byte} : rdata;
    end

endmodule

// File: rtl/data_mem_interface.sv
// rtl/data_mem_interface.sv - single-outstanding load/store bus master that stalls the pipeline
module data_mem_interface
    import data_mem_interface_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              read_mem,
    input  logic              write_mem,
    input  logic              load_byte,
    input  logic              store_byte,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] store_data,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic [3:0]        bus_sel,
    output logic              bus_read,
    output logic              bus_write,
    output logic [DATA_W-1:0] load_data,
    output logic              data_valid,
    output logic              bus_error,
    output logic              stall
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    mem_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic [3:0]        bus_sel_q, bus_sel_d;
    logic              bus_read_q, bus_read_d;
    logic              bus_write_q, bus_write_d;
    logic [DATA_W-1:0] load_data_q, load_data_d;
    logic              data_valid_q, data_valid_d;
    logic              bus_error_q, bus_error_d;
    logic              ld_byte_q, ld_byte_d;
    logic [1:0]        ld_off_q, ld_off_d;

    logic [3:0]        fmt_sel;
    logic [DATA_W-1:0] fmt_wdata;
    logic [DATA_W-1:0] fmt_load;

    // Store lanes come straight from the request inputs; load formatting uses the latched offset.
    byte_lane_formatter u_fmt (
        .store_byte (store_byte),
        .st_off     (address[1:0]),
        .store_data (store_data),
        .sel        (fmt_sel),
        .wdata      (fmt_wdata),
        .load_byte  (ld_byte_q),
        .ld_off     (ld_off_q),
        .rdata      (bus_rdata),
        .load_data  (fmt_load)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        bus_sel_d    = bus_sel_q;
        bus_read_d   = bus_read_q;
        bus_write_d  = bus_write_q;
        load_data_d  = load_data_q;
        data_valid_d = 1'b0;
        bus_error_d  = 1'b0;
        ld_byte_d    = ld_byte_q;
        ld_off_d     = ld_off_q;
        stall        = 1'b0;

        case (state_q)
            IDLE: begin
                stall = read_mem | write_mem;
                if (read_mem | write_mem) begin
                    state_d     = BUS;
                    cnt_d       = '0;
                    bus_addr_d  = {address[ADDR_W-1:2], 2'b00};
                    bus_write_d = write_mem;
                    bus_read_d  = read_mem & ~write_mem;
                    bus_sel_d   = write_mem ? fmt_sel : SEL_WORD;
                    bus_wdata_d = write_mem ? fmt_wdata : '0;
                    ld_byte_d   = load_byte;
                    ld_off_d    = address[1:0];
                end
            end
            BUS: begin
                stall = 1'b1;
                cnt_d = cnt_q + CNT_W'(1);
                if (bus_ack) begin
                    state_d      = DONE;
                    bus_read_d   = 1'b0;
                    bus_write_d  = 1'b0;
                    data_valid_d = bus_read_q;
                    if (bus_read_q) load_data_d = fmt_load;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d     = DONE;
                    bus_read_d  = 1'b0;
                    bus_write_d = 1'b0;
                    load_data_d = '0;
                    bus_error_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            bus_sel_q    <= '0;
            bus_read_q   <= 1'b0;
            bus_write_q  <= 1'b0;
            load_data_q  <= '0;
            data_valid_q <= 1'b0;
            bus_error_q  <= 1'b0;
            ld_byte_q    <= 1'b0;
            ld_off_q     <= 2'b00;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            bus_sel_q    <= bus_sel_d;
            bus_read_q   <= bus_read_d;
            bus_write_q  <= bus_write_d;
            load_data_q  <= load_data_d;
            data_valid_q <= data_valid_d;
            bus_error_q  <= bus_error_d;
            ld_byte_q    <= ld_byte_d;
            ld_off_q     <= ld_off_d;
        end
    end

    assign bus_addr   = bus_addr_q;
    assign bus_wdata  = bus_wdata_q;
    assign bus_sel    = bus_sel_q;
    assign bus_read   = bus_read_q;
    assign bus_write  = bus_write_q;
    assign load_data  = load_data_q;
    assign data_valid = data_valid_q;
    assign bus_error  = bus_error_q;

endmodule

// File: tb/tb_data_mem_interface.sv
// tb/tb_data_mem_interface.sv - scoreboard bench for the memory-access stage
module tb_data_mem_interface;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        read_mem = 1'b0, write_mem = 1'b0, load_byte = 1'b0, store_byte = 1'b0;
    logic [31:0] address = '0, store_data = '0, bus_rdata = '0;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_addr, bus_wdata, load_data;
    logic [3:0]  bus_sel;
    logic        bus_read, bus_write, data_valid, bus_error, stall;

    typedef struct {
        bit          err;
        logic [31:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    data_mem_interface #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .read_mem   (read_mem),
        .write_mem  (write_mem),
        .load_byte  (load_byte),
        .store_byte (store_byte),
        .address    (address),
        .store_data (store_data),
        .bus_rdata  (bus_rdata),
        .bus_ack    (bus_ack),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_sel    (bus_sel),
        .bus_read   (bus_read),
        .bus_write  (bus_write),
        .load_data  (load_data),
        .data_valid (data_valid),
        .bus_error  (bus_error),
        .stall      (stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Every completion or error pulse must match the oldest outstanding read expectation.
    always @(negedge clk) begin
        if (!rst && (data_valid || bus_error)) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_pulse", {30'd0, bus_error, data_valid}, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("pulse_error", {31'd0, bus_error}, {31'd0, e.err});
                chk("pulse_valid", {31'd0, data_valid}, {31'd0, ~e.err});
                chk("load_data", load_data, e.data);
            end
        end
    end

    task automatic do_txn(input bit rd, input bit wr, input bit lb, input bit sb,
                          input logic [31:0] addr, input logic [31:0] sdata,
                          input int ack_delay, input logic [31:0] rdata,
                          input logic [31:0] exp_addr, input logic [3:0] exp_sel,
                          input logic [31:0] exp_wdata, input logic [31:0] exp_ld,
                          input int exp_stall);
        int bus_cycles;
        exp_t e;
        bit exp_rd;
        exp_rd = rd && !wr;
        if (exp_rd) begin
            e.err  = (ack_delay < 0);
            e.data = exp_ld;
            sb_q.push_back(e);
        end
        @(negedge clk);
        read_mem = rd; write_mem = wr; load_byte = lb; store_byte = sb;
        address = addr; store_data = sdata;
        #1 chk("stall_idle", {31'd0, stall}, 32'd1);
        @(negedge clk);
        chk("bus_addr", bus_addr, exp_addr);
        chk("bus_sel", {28'd0, bus_sel}, {28'd0, exp_sel});
        if (wr) chk("bus_wdata", bus_wdata, exp_wdata);
        bus_cycles = 0;
        while (stall && bus_cycles < 100) begin
            chk("bus_read_held", {31'd0, bus_read}, {31'd0, exp_rd});
            chk("bus_write_held", {31'd0, bus_write}, {31'd0, wr});
            if (bus_cycles == ack_delay) begin
                bus_ack = 1'b1;
                bus_rdata = rdata;
            end
            bus_cycles++;
            @(negedge clk);
            bus_ack = 1'b0;
            #1;
        end
        chk("stall_done", {31'd0, stall}, 32'd0);
        chk("strobes_done", {30'd0, bus_read, bus_write}, 32'd0);
        chk("stall_cycles", 32'(1 + bus_cycles), 32'(exp_stall));
        read_mem = 1'b0; write_mem = 1'b0; load_byte = 1'b0; store_byte = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #2;
        chk("rst_addr", bus_addr, 32'd0);
        chk("rst_strobes", {28'd0, bus_sel, bus_read, bus_write}, 32'd0);
        chk("rst_pulses", {30'd0, data_valid, bus_error}, 32'd0);
        chk("rst_load", load_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("idle_no_req_stall", {31'd0, stall}, 32'd0);

        do_txn(1, 0, 0, 0, 32'h0000_0104, 32'h0, 1, 32'hDEAD_BEEF,
               32'h104, 4'b1111, 32'h0, 32'hDEAD_BEEF, 3);
        do_txn(0, 1, 0, 1, 32'h0000_0103, 32'h1234_56AB, 0, 32'h0,
               32'h100, 4'b1000, 32'hABAB_ABAB, 32'h0, 2);
        do_txn(1, 0, 1, 0, 32'h0000_0102, 32'h0, 0, 32'h12F4_5678,
               32'h100, 4'b1111, 32'h0, 32'hFFFF_FFF4, 2);
        do_txn(1, 0, 1, 0, 32'h0000_0101, 32'h0, 2, 32'h12F4_5678,
               32'h100, 4'b1111, 32'h0, 32'h0000_0056, 4);
        do_txn(0, 1, 0, 0, 32'h0000_0010, 32'hCAFE_F00D, 3, 32'h0,
               32'h10, 4'b1111, 32'hCAFE_F00D, 32'h0, 5);
        do_txn(1, 0, 0, 0, 32'h0000_0207, 32'h0, 0, 32'h8765_4321,
               32'h204, 4'b1111, 32'h0, 32'h8765_4321, 2);
        do_txn(1, 0, 0, 0, 32'h0000_0300, 32'h0, -1, 32'h0,
               32'h300, 4'b1111, 32'h0, 32'h0, 17);
        do_txn(1, 1, 0, 0, 32'h0000_0200, 32'h5555_AAAA, 1, 32'hFFFF_FFFF,
               32'h200, 4'b1111, 32'h5555_AAAA, 32'h0, 3);

        // Reset mid-transaction: strobes drop asynchronously and a late ack is ignored.
        @(negedge clk);
        write_mem = 1'b1; address = 32'h0000_0040; store_data = 32'h0BAD_F00D;
        @(negedge clk);
        chk("rstmid_write_up", {31'd0, bus_write}, 32'd1);
        write_mem = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rstmid_write", {31'd0, bus_write}, 32'd0);
        chk("rstmid_sel", {28'd0, bus_sel}, 32'd0);
        chk("rstmid_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus_ack = 1'b1;
        bus_rdata = 32'h1111_2222;
        repeat (3) @(negedge clk);
        bus_ack = 1'b0;
        chk("late_ack_strobes", {30'd0, bus_read, bus_write}, 32'd0);
        chk("late_ack_stall", {31'd0, stall}, 32'd0);
        repeat (2) @(negedge clk);

        chk("queue_empty", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
